axis_upsizer: RTL and testbench

Parametrised single-clock AXI-Stream width upsizer. It packs RATIO narrow input beats of IN_BYTES bytes each into one output word of IN_BYTES*RATIO bytes. It is the generalised successor of the fixed 8-to-32 packer in the UDP receive path. Unlike that packer, it has:
- true backpressure through the packing stage,
- input tkeep on the final beat,
- a selectable lane order,
- a first-word flag,
- a packet counter.

Clock-domain crossing is not done here; an external FIFO is placed on either side when needed.

---
 rtl/axis_upsizer.sv | 89 ++++++++
 tb/tb_axis_upsizer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_upsizer.sv
// axis_upsizer: packs RATIO narrow AXI-Stream beats into one wide word with backpressure, lane order, tfirst and packet count
module axis_upsizer #(
  parameter int IN_BYTES  = 1,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [8*IN_BYTES-1:0]        s_axis_tdata,
  input  logic [IN_BYTES-1:0]          s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [8*IN_BYTES*RATIO-1:0]  m_axis_tdata,
  output logic [IN_BYTES*RATIO-1:0]    m_axis_tkeep,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tfirst,
  input  logic                         m_axis_tready,
  output logic [CNT_W-1:0]             pkt_cnt
);
  localparam int DW = 8 * IN_BYTES;
  localparam int OW = DW * RATIO;
  localparam int KW = IN_BYTES * RATIO;
  localparam int LW = $clog2(RATIO);

  logic [LW-1:0]    lane_q, lane_d, lane_l;
  logic [OW-1:0]    acc_data_q, acc_data_d, data_mrg, m_data_q, m_data_d;
  logic [KW-1:0]    acc_keep_q, acc_keep_d, keep_mrg, m_keep_q, m_keep_d;
  logic             first_q, first_d, m_valid_q, m_valid_d, m_last_q, m_last_d, m_first_q, m_first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, done;

  // Merge the incoming beat into its lane and derive the next state of every register.
  // The output register may reload in the same cycle it is handshaken, which gives full rate.
  always_comb begin
    s_axis_tready = ~m_valid_q | m_axis_tready;
    accept        = s_axis_tvalid & s_axis_tready;
    done          = accept & (s_axis_tlast | (lane_q == LW'(RATIO - 1)));
    lane_l        = (MSB_FIRST != 0) ? LW'(RATIO - 1) - lane_q : lane_q;
    data_mrg      = acc_data_q | (OW'(s_axis_tdata) << (DW * lane_l));
    keep_mrg      = acc_keep_q | (KW'(s_axis_tkeep) << (IN_BYTES * lane_l));
    lane_d        = done ? '0 : accept ? lane_q + LW'(1) : lane_q;
    acc_data_d    = done ? '0 : accept ? data_mrg : acc_data_q;
    acc_keep_d    = done ? '0 : accept ? keep_mrg : acc_keep_q;
    first_d       = done ? s_axis_tlast : first_q;
    m_valid_d     = done | (m_valid_q & ~m_axis_tready);
    m_data_d      = done ? data_mrg : m_data_q;
    m_keep_d      = done ? keep_mrg : m_keep_q;
    m_last_d      = done ? s_axis_tlast : m_last_q;
    m_first_d     = done ? first_q : m_first_q;
    cnt_d         = cnt_q + CNT_W'(m_valid_q & m_axis_tready & m_last_q);
  end

  // State registers; reset drops any partial or held word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q     <= '0;
      acc_data_q <= '0;
      acc_keep_q <= '0;
      first_q    <= 1'b1;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      m_first_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      lane_q     <= lane_d;
      acc_data_q <= acc_data_d;
      acc_keep_q <= acc_keep_d;
      first_q    <= first_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
      m_first_q  <= m_first_d;
      cnt_q      <= cnt_d;
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tfirst = m_first_q;
  assign pkt_cnt       = cnt_q;
endmodule

// File: tb/tb_axis_upsizer.sv
// tb_axis_upsizer: directed self-checking bench for axis_upsizer in two configurations
module tb_axis_upsizer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [7:0]  a_sd;
  logic        a_sk, a_sv, a_sl, a_sr, a_mv, a_ml, a_mf, a_mr;
  logic [31:0] a_md, a_cnt;
  logic [3:0]  a_mk;

  logic [15:0] b_sd;
  logic [1:0]  b_sk;
  logic        b_sv, b_sl, b_sr, b_mv, b_ml, b_mf, b_mr;
  logic [31:0] b_md, b_cnt;
  logic [3:0]  b_mk;

  int total = 0, bad = 0, cyc = 0, stalls = 0, held_err = 0;
  logic [31:0] wd[$];
  logic [3:0]  wk[$];
  logic        wl[$], wf[$];
  int          wc[$];
  logic [7:0]  exp_b[$];

  axis_upsizer #(.IN_BYTES(1), .RATIO(4), .MSB_FIRST(1), .CNT_W(32)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(a_sd), .s_axis_tkeep(a_sk), .s_axis_tvalid(a_sv), .s_axis_tlast(a_sl), .s_axis_tready(a_sr),
    .m_axis_tdata(a_md), .m_axis_tkeep(a_mk), .m_axis_tvalid(a_mv), .m_axis_tlast(a_ml), .m_axis_tfirst(a_mf),
    .m_axis_tready(a_mr), .pkt_cnt(a_cnt)
  );

  axis_upsizer #(.IN_BYTES(2), .RATIO(2), .MSB_FIRST(0), .CNT_W(32)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(b_sd), .s_axis_tkeep(b_sk), .s_axis_tvalid(b_sv), .s_axis_tlast(b_sl), .s_axis_tready(b_sr),
    .m_axis_tdata(b_md), .m_axis_tkeep(b_mk), .m_axis_tvalid(b_mv), .m_axis_tlast(b_ml), .m_axis_tfirst(b_mf),
    .m_axis_tready(b_mr), .pkt_cnt(b_cnt)
  );

  // Inputs change only just after posedge, so the negedge view predicts the next handshake.
  always @(negedge clk) begin
    cyc++;
    if (a_mv && a_mr) begin
      wd.push_back(a_md);
      wk.push_back(a_mk);
      wl.push_back(a_ml);
      wf.push_back(a_mf);
      wc.push_back(cyc);
    end
    if (!a_sr) begin
      stalls++;
      if (!a_mv) held_err++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wd.delete(); wk.delete(); wl.delete(); wf.delete(); wc.delete();
    stalls = 0;
    held_err = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    a_sv = 1'b0; a_sl = 1'b0; b_sv = 1'b0; b_sl = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    clr();
  endtask

  task automatic send_a(input logic [7:0] d, input logic k, input logic l);
    int n;
    a_sd = d; a_sk = k; a_sl = l; a_sv = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (a_sr) break;
      n++;
    end
    chk("a_accept", a_sr, 1);
    @(posedge clk); #1;
    a_sv = 1'b0; a_sl = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] d, input logic [1:0] k, input logic l);
    int n;
    b_sd = d; b_sk = k; b_sl = l; b_sv = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (b_sr) break;
      n++;
    end
    chk("b_accept", b_sr, 1);
    @(posedge clk); #1;
    b_sv = 1'b0; b_sl = 1'b0;
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 400 && wd.size() < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input int i, input logic [31:0] d, input logic [3:0] k,
                          input logic f, input logic l);
    chk({tag, "_data"}, wd.size() > i ? wd[i] : 32'hx, d);
    chk({tag, "_keep"}, wk.size() > i ? wk[i] : 4'hx, k);
    chk({tag, "_first"}, wf.size() > i ? wf[i] : 1'bx, f);
    chk({tag, "_last"}, wl.size() > i ? wl[i] : 1'bx, l);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit done;
    int errs;
    a_sd = '0; a_sk = 1'b1; a_sv = 1'b0; a_sl = 1'b0; a_mr = 1'b1;
    b_sd = '0; b_sk = 2'b11; b_sv = 1'b0; b_sl = 1'b0; b_mr = 1'b1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", a_mv, 0);
    chk("rst_data", a_md, 0);
    chk("rst_keep", a_mk, 0);
    chk("rst_last", a_ml, 0);
    chk("rst_first", a_mf, 0);
    chk("rst_cnt", a_cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    clr();
    chk("rst_sready", a_sr, 1);

    send_a(8'h11, 1, 0); send_a(8'h22, 1, 0); send_a(8'h33, 1, 0); send_a(8'h44, 1, 1);
    chk("t1_lat_valid", a_mv, 1);
    chk("t1_lat_data", a_md, 32'h11223344);
    wait_words(1);
    chk("t1_words", wd.size(), 1);
    chk_word("t1", 0, 32'h11223344, 4'hF, 1, 1);
    chk("t1_cnt", a_cnt, 1);

    clr();
    for (int i = 1; i <= 6; i++) send_a(8'hA0 + 8'(i), 1, i == 6);
    wait_words(2);
    chk("t2_words", wd.size(), 2);
    chk_word("t2w0", 0, 32'hA1A2A3A4, 4'hF, 1, 0);
    chk_word("t2w1", 1, 32'hA5A60000, 4'hC, 0, 1);
    chk("t2_cnt", a_cnt, 2);

    clr();
    for (int i = 1; i <= 4; i++) send_a(8'(i), 1, 0);
    send_a(8'h00, 0, 1);
    wait_words(2);
    chk_word("zk0w0", 0, 32'h01020304, 4'hF, 1, 0);
    chk_word("zk0w1", 1, 32'h00000000, 4'h0, 0, 1);
    chk("zk0_cnt", a_cnt, 3);

    clr();
    send_a(8'h5A, 1, 0);
    send_a(8'h00, 0, 1);
    wait_words(1);
    chk_word("zkmid", 0, 32'h5A000000, 4'h8, 1, 1);
    chk("zkmid_cnt", a_cnt, 4);

    do_reset();
    exp_b.delete();
    for (int p = 0; p < 3; p++) for (int i = 0; i < 8; i++) exp_b.push_back(8'(p * 16 + i + 1));
    done = 1'b0;
    fork
      begin
        for (int j = 0; j < 24; j++) send_a(exp_b[j], 1, (j % 8) == 7);
        wait_words(6);
        done = 1'b1;
      end
      begin
        while (!done) begin
          a_mr = 1'b1;
          @(posedge clk); #1;
          a_mr = 1'b0;
          repeat (2) begin @(posedge clk); #1; end
        end
        a_mr = 1'b1;
      end
    join
    chk("bp_words", wd.size(), 6);
    errs = 0;
    for (int w = 0; w < wd.size() && w < 6; w++) begin
      for (int j = 0; j < 4; j++) if (wd[w][31 - 8 * j -: 8] !== exp_b[w * 4 + j]) errs++;
      if (wk[w] !== 4'hF || wf[w] !== ((w % 2) == 0) || wl[w] !== ((w % 2) == 1)) errs++;
    end
    chk("bp_bytes", errs, 0);
    chk("bp_cnt", a_cnt, 3);
    chk("bp_held", held_err, 0);
    chk("bp_stalled", stalls > 0, 1);

    do_reset();
    for (int j = 0; j < 64; j++) send_a(8'(j), 1, j == 63);
    wait_words(16);
    chk("cs_words", wd.size(), 16);
    chk("cs_stalls", stalls, 0);
    errs = 0;
    for (int w = 1; w < wc.size(); w++) if (wc[w] - wc[w - 1] != 4) errs++;
    chk("cs_spacing", errs, 0);
    errs = 0;
    for (int w = 0; w < wd.size(); w++) if (wl[w] !== (w == 15) || wf[w] !== (w == 0)) errs++;
    chk("cs_flags", errs, 0);
    chk_word("cs_w15", 15, 32'h3C3D3E3F, 4'hF, 0, 1);
    chk("cs_cnt", a_cnt, 1);

    send_a(8'h77, 1, 0);
    send_a(8'h88, 1, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_valid", a_mv, 0);
    chk("mr_data", a_md, 0);
    chk("mr_keep", a_mk, 0);
    chk("mr_cnt", a_cnt, 0);
    chk("mr_last", a_ml, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    clr();
    send_a(8'hDE, 1, 0); send_a(8'hAD, 1, 0); send_a(8'hBE, 1, 0); send_a(8'hEF, 1, 1);
    wait_words(1);
    repeat (4) @(posedge clk);
    #1;
    chk("mr_words", wd.size(), 1);
    chk_word("mr", 0, 32'hDEADBEEF, 4'hF, 1, 1);
    chk("mr_cnt_after", a_cnt, 1);

    send_b(16'h1234, 2'b11, 0);
    send_b(16'h0056, 2'b01, 1);
    chk("b_valid", b_mv, 1);
    chk("b_data", b_md, 32'h00561234);
    chk("b_keep", b_mk, 4'h7);
    chk("b_last", b_ml, 1);
    chk("b_first", b_mf, 1);
    @(posedge clk); #1;
    chk("b_cnt", b_cnt, 1);
    chk("b_drained", b_mv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
